// File: rtl/sha1_pkg.sv
// sha1_pkg: shared constants and types for the SHA1 Wishbone sequencer.
//   - Register offsets of the engine relative to its base address.
//   - OPS bit positions and the OPS values written by the sequencer.
//   - Engine response constants (MSG_IN ack, DIGEST busy marker).
//   - Error-cause and sequencer-state enums.
package sha1_pkg;

  localparam logic [31:0] OPS_OFF    = 32'h08;
  localparam logic [31:0] MSG_IN_OFF = 32'h0C;
  localparam logic [31:0] DIGEST_OFF = 32'h10;

  localparam int OPS_ON    = 0;
  localparam int OPS_RESET = 1;
  localparam int OPS_PANIC = 2;
  localparam int OPS_DONE  = 3;

  // Clear pass: ON|RESET clears done and the indices, then RESET alone
  // leaves the engine off with its compute state held in reset.
  localparam logic [31:0] OPS_CLR_ON  = (32'd1 << OPS_ON) | (32'd1 << OPS_RESET);
  localparam logic [31:0] OPS_CLR_RST = (32'd1 << OPS_RESET);
  localparam logic [31:0] OPS_OFF_VAL = 32'h0;

  localparam logic [31:0] ACK_VAL   = 32'h0000_0001;
  localparam logic [31:0] EBUSY_VAL = 32'hffff_fff0;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_NACK    = 2'd1,
    ERR_PANIC   = 2'd2,
    ERR_TIMEOUT = 2'd3
  } err_code_e;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CLR_ON,
    S_CLR_RST,
    S_LOAD,
    S_POLL,
    S_READ,
    S_OFF,
    S_PRESENT,
    S_ERROR
  } state_e;

endpackage

// File: rtl/sha1_wb_master_port.sv
// sha1_wb_master_port: single-transaction Wishbone master.
//   req/req_we/req_adr/req_dat : operation request, taken when rdy is high
//   rdy                        : no transaction outstanding
//   done/rdata                 : ack cycle of the outstanding transaction and
//                                the slave data seen in that cycle
//   wbm_*                      : registered Wishbone master signals
// A request is registered on the edge it is taken and held until ack is
// sampled; the bus drops on that edge. rdy returns the cycle after the ack,
// so a new request reaches the bus no earlier than one idle cycle later.
module sha1_wb_master_port (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        req,
  input  logic        req_we,
  input  logic [31:0] req_adr,
  input  logic [31:0] req_dat,
  output logic        rdy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic        wbm_ack_i,
  input  logic [31:0] wbm_dat_i
);

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      wbm_cyc_o <= 1'b0;
      wbm_stb_o <= 1'b0;
      wbm_we_o  <= 1'b0;
      wbm_adr_o <= 32'h0;
      wbm_dat_o <= 32'h0;
    end else if (done) begin
      wbm_cyc_o <= 1'b0;
      wbm_stb_o <= 1'b0;
    end else if (req && rdy) begin
      wbm_cyc_o <= 1'b1;
      wbm_stb_o <= 1'b1;
      wbm_we_o  <= req_we;
      wbm_adr_o <= req_adr;
      wbm_dat_o <= req_dat;
    end
  end

  assign rdy       = ~wbm_cyc_o;
  // A late re-pulse of ack after stb has dropped is not a completion.
  assign done      = wbm_stb_o & wbm_ack_i;
  assign rdata     = wbm_dat_i;
  assign wbm_sel_o = 4'hF;

endmodule

// File: rtl/sha1_wb_sequencer.sv
// sha1_wb_sequencer: drives one 512-bit block through the SHA1 engine.
//   start                      : one-cycle request, honoured only in IDLE
//   busy                       : block active (not IDLE)
//   msg_valid/msg_ready/msg_data : sixteen message words, word 0 first
//   dig_valid/dig_ready/dig_data : 160-bit digest {h0,h1,h2,h3,h4}
//   err/err_code               : sticky error and cause, cleared by start
//   wbm_*                      : Wishbone master to the engine
// Sequence: OPS=3, OPS=2, 16x MSG_IN, poll OPS, 5x DIGEST, OPS=0, present.
module sha1_wb_sequencer
  import sha1_pkg::*;
#(
  parameter logic [31:0] BASE_ADDRESS = 32'h3000_0024,
  parameter int          POLL_TIMEOUT = 1024,
  parameter int          TIMEOUT_W    = 11
) (
  input  logic         wb_clk_i,
  input  logic         wb_rst_ni,
  input  logic         start,
  output logic         busy,
  input  logic         msg_valid,
  output logic         msg_ready,
  input  logic [31:0]  msg_data,
  output logic         dig_valid,
  input  logic         dig_ready,
  output logic [159:0] dig_data,
  output logic         err,
  output logic [1:0]   err_code,
  output logic         wbm_cyc_o,
  output logic         wbm_stb_o,
  output logic         wbm_we_o,
  output logic [3:0]   wbm_sel_o,
  output logic [31:0]  wbm_adr_o,
  output logic [31:0]  wbm_dat_o,
  input  logic         wbm_ack_i,
  input  logic [31:0]  wbm_dat_i
);

  localparam logic [31:0] ADR_OPS = BASE_ADDRESS + OPS_OFF;
  localparam logic [31:0] ADR_MSG = BASE_ADDRESS + MSG_IN_OFF;
  localparam logic [31:0] ADR_DIG = BASE_ADDRESS + DIGEST_OFF;

  state_e                 state_q, state_d;
  logic                   req, req_we, rdy, done;
  logic [31:0]            req_adr, req_dat, rdata;
  logic [3:0]             wcnt;
  logic [TIMEOUT_W-1:0]   pcnt;
  logic [2:0]             rcnt;
  logic [159:0]           dig_q;
  logic                   err_q;
  err_code_e              err_code_q;
  logic                   start_acc, nack, rd_busy, poll_last;

  sha1_wb_master_port u_port (
    .wb_clk_i  (wb_clk_i),
    .wb_rst_ni (wb_rst_ni),
    .req       (req),
    .req_we    (req_we),
    .req_adr   (req_adr),
    .req_dat   (req_dat),
    .rdy       (rdy),
    .done      (done),
    .rdata     (rdata),
    .wbm_cyc_o (wbm_cyc_o),
    .wbm_stb_o (wbm_stb_o),
    .wbm_we_o  (wbm_we_o),
    .wbm_sel_o (wbm_sel_o),
    .wbm_adr_o (wbm_adr_o),
    .wbm_dat_o (wbm_dat_o),
    .wbm_ack_i (wbm_ack_i),
    .wbm_dat_i (wbm_dat_i)
  );

  assign start_acc = start && (state_q == S_IDLE);
  assign nack      = (rdata != ACK_VAL);
  assign rd_busy   = (rdata == EBUSY_VAL);
  assign poll_last = (pcnt == TIMEOUT_W'(POLL_TIMEOUT - 1));

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) state_q <= S_IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start) state_d = S_CLR_ON;
      S_CLR_ON:  if (done) state_d = S_CLR_RST;
      S_CLR_RST: if (done) state_d = S_LOAD;
      S_LOAD:
        if (done) begin
          if (nack)               state_d = S_ERROR;
          else if (wcnt == 4'd15) state_d = S_POLL;
        end
      S_POLL:
        if (done) begin
          if (rdata[OPS_DONE])       state_d = S_READ;
          else if (rdata[OPS_PANIC]) state_d = S_ERROR;
          else if (poll_last)        state_d = S_ERROR;
        end
      S_READ:
        if (done) begin
          if (rd_busy)            state_d = S_ERROR;
          else if (rcnt == 3'd4)  state_d = S_OFF;
        end
      S_OFF:     if (done) state_d = S_PRESENT;
      S_PRESENT: if (dig_ready) state_d = S_IDLE;
      S_ERROR:   if (done) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Every bus-issuing state requests while the port is free; the port's own
  // busy flag keeps a state from issuing twice before its ack moves it on.
  always_comb begin
    req       = 1'b0;
    req_we    = 1'b1;
    req_adr   = ADR_OPS;
    req_dat   = OPS_OFF_VAL;
    msg_ready = 1'b0;
    case (state_q)
      S_CLR_ON:  begin req = rdy; req_dat = OPS_CLR_ON;  end
      S_CLR_RST: begin req = rdy; req_dat = OPS_CLR_RST; end
      S_LOAD: begin
        msg_ready = rdy;
        req       = rdy & msg_valid;
        req_adr   = ADR_MSG;
        req_dat   = msg_data;
      end
      S_POLL:    begin req = rdy; req_we = 1'b0; end
      S_READ:    begin req = rdy; req_we = 1'b0; req_adr = ADR_DIG; end
      S_OFF,
      S_ERROR:   req = rdy;
      default:   ;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      wcnt       <= '0;
      pcnt       <= '0;
      rcnt       <= '0;
      dig_q      <= '0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
    end else if (start_acc) begin
      wcnt       <= '0;
      pcnt       <= '0;
      rcnt       <= '0;
      dig_q      <= '0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
    end else if (done) begin
      case (state_q)
        S_LOAD:
          if (nack) begin
            err_q      <= 1'b1;
            err_code_q <= ERR_NACK;
          end else begin
            wcnt <= wcnt + 4'd1;
          end
        S_POLL:
          if (!rdata[OPS_DONE]) begin
            if (rdata[OPS_PANIC]) begin
              err_q      <= 1'b1;
              err_code_q <= ERR_PANIC;
            end else begin
              pcnt <= pcnt + TIMEOUT_W'(1);
              if (poll_last) begin
                err_q      <= 1'b1;
                err_code_q <= ERR_TIMEOUT;
              end
            end
          end
        S_READ:
          if (rd_busy) begin
            err_q      <= 1'b1;
            err_code_q <= ERR_PANIC;
          end else begin
            // Engine returns h4 first; each word enters at the top so the
            // first read settles in the low word and h0 ends up highest.
            dig_q <= {rdata, dig_q[159:32]};
            rcnt  <= rcnt + 3'd1;
          end
        default: ;
      endcase
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign dig_valid = (state_q == S_PRESENT);
  assign dig_data  = dig_q;
  assign err       = err_q;
  assign err_code  = err_code_q;

endmodule

// File: tb/tb_sha1_wb_sequencer.sv
// tb_sha1_wb_sequencer: directed bench for sha1_wb_sequencer with a
// Wishbone slave model that logs every acked transaction.
module tb_sha1_wb_sequencer;

  localparam logic [31:0]  BASE    = 32'h3000_0024;
  localparam logic [31:0]  A_OPS   = BASE + 32'h08;
  localparam logic [31:0]  A_MSG   = BASE + 32'h0C;
  localparam logic [31:0]  A_DIG   = BASE + 32'h10;
  localparam logic [159:0] EXP_DIG =
    160'hA9993E36_4706816A_BA3E2571_7850C26C_9CD0D89D;

  logic         wb_clk_i = 1'b0;
  logic         wb_rst_ni = 1'b1;
  logic         start = 1'b0;
  logic         busy;
  logic         msg_valid = 1'b0;
  logic         msg_ready;
  logic [31:0]  msg_data = 32'h0;
  logic         dig_valid;
  logic         dig_ready = 1'b0;
  logic [159:0] dig_data;
  logic         err;
  logic [1:0]   err_code;
  logic         wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [3:0]   wbm_sel_o;
  logic [31:0]  wbm_adr_o, wbm_dat_o;
  logic         wbm_ack_i = 1'b0;
  logic [31:0]  wbm_dat_i = 32'h0;

  always #5 wb_clk_i = ~wb_clk_i;

  sha1_wb_sequencer #(
    .BASE_ADDRESS (BASE),
    .POLL_TIMEOUT (4),
    .TIMEOUT_W    (3)
  ) dut (
    .wb_clk_i  (wb_clk_i),
    .wb_rst_ni (wb_rst_ni),
    .start     (start),
    .busy      (busy),
    .msg_valid (msg_valid),
    .msg_ready (msg_ready),
    .msg_data  (msg_data),
    .dig_valid (dig_valid),
    .dig_ready (dig_ready),
    .dig_data  (dig_data),
    .err       (err),
    .err_code  (err_code),
    .wbm_cyc_o (wbm_cyc_o),
    .wbm_stb_o (wbm_stb_o),
    .wbm_we_o  (wbm_we_o),
    .wbm_sel_o (wbm_sel_o),
    .wbm_adr_o (wbm_adr_o),
    .wbm_dat_o (wbm_dat_o),
    .wbm_ack_i (wbm_ack_i),
    .wbm_dat_i (wbm_dat_i)
  );

  // ---------------- slave model ----------------
  logic [31:0] words [16];
  logic [31:0] dtbl  [5];
  int          nack_word = -1;
  int          done_on   = 3;   // 0: never report done
  bit          repulse   = 1'b0;
  bit          bfm_clr   = 1'b0;
  int          n_msg = 0, n_poll = 0, n_dig = 0, n_log = 0;
  logic [64:0] lg [64];

  function automatic logic [31:0] respond();
    if (wbm_we_o)
      return (wbm_adr_o == A_MSG && n_msg == nack_word) ? 32'h0fff_ffea : 32'h1;
    if (wbm_adr_o == A_OPS)
      return (done_on != 0 && n_poll + 1 >= done_on) ? 32'h8 : 32'h0;
    if (wbm_adr_o == A_DIG && n_dig < 5)
      return dtbl[n_dig];
    return 32'hdead_beef;
  endfunction

  always @(posedge wb_clk_i) begin
    if (bfm_clr) begin
      n_msg <= 0; n_poll <= 0; n_dig <= 0; n_log <= 0;
      wbm_ack_i <= 1'b0;
    end else if (wbm_stb_o && wbm_ack_i) begin
      if (n_log < 64)
        lg[n_log] <= {wbm_we_o, wbm_adr_o, wbm_we_o ? wbm_dat_o : 32'h0};
      n_log <= n_log + 1;
      if (wbm_adr_o == A_MSG) n_msg <= n_msg + 1;
      if (wbm_adr_o == A_OPS && !wbm_we_o) n_poll <= n_poll + 1;
      if (wbm_adr_o == A_DIG) n_dig <= n_dig + 1;
      wbm_ack_i <= repulse;   // optional stray ack after stb drops
    end else if (wbm_stb_o) begin
      wbm_ack_i <= 1'b1;
      wbm_dat_i <= respond();
    end else begin
      wbm_ack_i <= 1'b0;
    end
  end

  // ---------------- checking ----------------
  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic clr_bfm();
    bfm_clr = 1'b1;
    tick();
    bfm_clr = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic feed(input int max_w, input bit rnd, output int nfed);
    nfed = 0;
    for (int c = 0; c < 3000 && nfed < max_w; c++) begin
      msg_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      msg_data  = words[nfed];
      @(negedge wb_clk_i);
      if (msg_valid && msg_ready) nfed++;
      else if (!busy) break;
      tick();
    end
    msg_valid = 1'b0;
  endtask

  task automatic wait_dv(input string nm);
    for (int c = 0; c < 2000 && !dig_valid; c++) @(negedge wb_clk_i);
    chk({nm, "_dv"}, dig_valid, 1'b1);
  endtask

  task automatic wait_idle(input string nm);
    for (int c = 0; c < 2000 && busy; c++) @(negedge wb_clk_i);
    chk({nm, "_idle"}, busy, 1'b0);
  endtask

  task automatic chk_log(input string nm);
    logic [64:0] e;
    chk({nm, "_ntx"}, n_log, 27);
    for (int i = 0; i < 27; i++) begin
      if (i == 0)      e = {1'b1, A_OPS, 32'h3};
      else if (i == 1) e = {1'b1, A_OPS, 32'h2};
      else if (i < 18) e = {1'b1, A_MSG, words[i-2]};
      else if (i < 21) e = {1'b0, A_OPS, 32'h0};
      else if (i < 26) e = {1'b0, A_DIG, 32'h0};
      else             e = {1'b1, A_OPS, 32'h0};
      chk($sformatf("%s_tx%0d", nm, i), lg[i], e);
    end
  endtask

  task automatic run_block(input string nm, input bit rnd);
    int nf;
    clr_bfm();
    pulse_start();
    chk({nm, "_busy"}, busy, 1'b1);
    chk({nm, "_errclr"}, err, 1'b0);
    feed(16, rnd, nf);
    chk({nm, "_nfed"}, nf, 16);
    wait_dv(nm);
    chk({nm, "_dig"}, dig_data, EXP_DIG);
    chk({nm, "_err"}, err, 1'b0);
    chk_log(nm);
  endtask

  task automatic release_dig(input string nm);
    tick();
    dig_ready = 1'b1;
    tick();
    dig_ready = 1'b0;
    @(negedge wb_clk_i);
    chk({nm, "_dv_drop"}, dig_valid, 1'b0);
    chk({nm, "_busy_drop"}, busy, 1'b0);
  endtask

  function automatic int count_ops_reads();
    int n = 0;
    for (int i = 0; i < 64; i++)
      if (i < n_log && lg[i] == {1'b0, A_OPS, 32'h0}) n++;
    return n;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int nf, stable;
    words[0] = 32'h6162_6380;
    for (int i = 1; i < 15; i++) words[i] = 32'h0;
    words[15] = 32'h0000_0018;
    dtbl[0] = 32'h9CD0D89D; dtbl[1] = 32'h7850C26C; dtbl[2] = 32'hBA3E2571;
    dtbl[3] = 32'h4706816A; dtbl[4] = 32'hA9993E36;

    // reset values, observed before any clock edge
    #1 wb_rst_ni = 1'b0;
    #2;
    chk("rst_cyc", wbm_cyc_o, 1'b0);
    chk("rst_stb", wbm_stb_o, 1'b0);
    chk("rst_we", wbm_we_o, 1'b0);
    chk("rst_sel", wbm_sel_o, 4'hF);
    chk("rst_adr", wbm_adr_o, 32'h0);
    chk("rst_dat", wbm_dat_o, 32'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_mrdy", msg_ready, 1'b0);
    chk("rst_dv", dig_valid, 1'b0);
    chk("rst_dig", dig_data, 160'h0);
    chk("rst_err", err, 1'b0);
    chk("rst_code", err_code, 2'd0);
    @(negedge wb_clk_i);
    wb_rst_ni = 1'b1;
    tick();

    // normal block, then hold the digest with stray starts
    run_block("basic", 1'b0);
    stable = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i == 3) start = 1'b1;
      if (i == 4) start = 1'b0;
      @(negedge wb_clk_i);
      if (dig_valid && dig_data == EXP_DIG) stable++;
    end
    chk("hold_stable", stable, 10);
    chk("hold_no_tx", n_log, 27);
    chk("hold_busy", busy, 1'b1);
    release_dig("basic");

    // MSG_IN nack on word 5
    nack_word = 5;
    clr_bfm();
    pulse_start();
    feed(16, 1'b0, nf);
    wait_idle("nack");
    chk("nack_nfed", nf, 6);
    chk("nack_nmsg", n_msg, 6);
    chk("nack_ntx", n_log, 9);
    chk("nack_off", lg[8], {1'b1, A_OPS, 32'h0});
    chk("nack_err", err, 1'b1);
    chk("nack_code", err_code, 2'd1);
    chk("nack_dv", dig_valid, 1'b0);
    nack_word = -1;

    // engine never done: poll timeout after 4 reads
    done_on = 0;
    clr_bfm();
    pulse_start();
    chk("to_errclr", err, 1'b0);
    chk("to_codeclr", err_code, 2'd0);
    feed(16, 1'b0, nf);
    wait_idle("to");
    chk("to_polls", count_ops_reads(), 4);
    chk("to_ntx", n_log, 23);
    chk("to_off", lg[22], {1'b1, A_OPS, 32'h0});
    chk("to_err", err, 1'b1);
    chk("to_code", err_code, 2'd3);
    done_on = 3;

    // stray ack re-pulse with a stalling source
    repulse = 1'b1;
    run_block("repulse", 1'b1);
    release_dig("repulse");
    repulse = 1'b0;

    // asynchronous reset during the word 8 write
    clr_bfm();
    pulse_start();
    feed(8, 1'b0, nf);
    chk("rstmid_nfed", nf, 8);
    msg_valid = 1'b1;
    msg_data  = words[8];
    for (int c = 0; c < 50; c++) begin
      @(negedge wb_clk_i);
      if (msg_ready) break;
    end
    tick();
    msg_valid = 1'b0;
    chk("rstmid_pre_stb", wbm_stb_o, 1'b1);
    #1 wb_rst_ni = 1'b0;
    #1;
    chk("rstmid_cyc", wbm_cyc_o, 1'b0);
    chk("rstmid_stb", wbm_stb_o, 1'b0);
    chk("rstmid_adr", wbm_adr_o, 32'h0);
    chk("rstmid_dat", wbm_dat_o, 32'h0);
    chk("rstmid_busy", busy, 1'b0);
    chk("rstmid_mrdy", msg_ready, 1'b0);
    @(negedge wb_clk_i);
    wb_rst_ni = 1'b1;
    tick();
    run_block("replay", 1'b0);
    release_dig("replay");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
